interrupt_controller: RTL and testbench
=======================================

# interrupt_controller

Source-side interrupt controller for the 16-bit datapath. Latches edge-triggered requests from four peripherals, arbitrates by a fixed per-source level, and presents the winner to the datapath's interrupt interface. It drives int0–int3, intLvl1/intLvl0, intDataIn and intWrite, and tracks the datapath's intr acknowledge from ack through end-of-interrupt. It sits between the peripheral request lines and the datapath in the top-level schematic.

## Interface
- LVL0, 2'd0: level of source 0 (3 = highest)
- LVL1, 2'd1: level of source 1
- LVL2, 2'd2: level of source 2
- LVL3, 2'd3: level of source 3
- VECTOR_BASE, 16'h0040: handler vector base; the vector is VECTOR_BASE + (idx << 2)
- ACK_TIMEOUT, 8'd64: cycles to wait for acknowledge (INTC_TIMEOUT_EN only)

Ports:
- CLK  in  1  system clock, rising edge
- Reset  in  1  synchronous, active-high
- devReq  in  4  peripheral request lines, rising-edge sensitive
- intr  in  1  datapath acknowledge; high while the handler is in service
- intDataOut  in  16  datapath data, sampled at end-of-interrupt
- int0, int1, int2, int3  out  1 each  one-hot selected source
- intLvl1, intLvl0  out  1 each  level of the selected source
- intDataIn  out  16  handler vector
- intWrite  out  1  single-cycle strobe announcing a new interrupt
- pending  out  4  latched, unserviced requests
- inService  out  4  one-hot source currently in service
- mask  out  4  masked sources (1 = masked)
- timeoutFlag  out  1  sticky; set when an acknowledge times out

## Operation
- devReq is registered once. A rising edge (prev 0, cur 1) on bit i sets pending[i].
- Eligible sources are pending & ~mask. The winner is the highest LVLi; on equal levels, the lower index wins.
- The FSM has four states: IDLE, ASSERT, WAIT_ACK, SERVICE.
- IDLE: if any source is eligible, register the winner idx. Drive int{idx}=1, {intLvl1,intLvl0}=LVLidx and intDataIn=vector, then go to ASSERT.
- ASSERT: intWrite=1 for exactly this cycle, then go to WAIT_ACK.
- WAIT_ACK: on intr=1, clear pending[idx], set inService[idx], and go to SERVICE.
- SERVICE: intN, level and intDataIn are held. On intr 1→0 (end-of-interrupt), clear inService and drop intN and the level.
  - At end-of-interrupt, if intDataOut[15]=1, then mask ← intDataOut[3:0]; otherwise mask is unchanged.
  - Then go to IDLE.
- intN, the level and intDataIn stay stable from ASSERT through SERVICE. Arbitration never re-evaluates mid-interrupt, so there is no nesting.
- A new edge on the in-service source during SERVICE sets pending again; that source is served again after end-of-interrupt.
- A rising edge and the ack clearing the same bit in the same cycle resolves to set wins; the new request is kept.
- Masking a pending source does not clear its pending bit. The source is served once unmasked.
- Reset values:
  - FSM in IDLE
  - pending, inService and mask = 0
  - int0–int3, intLvl1/0 and intWrite = 0
  - intDataIn = 0
  - timeoutFlag = 0
  - edge registers = 0, so a devReq already high at reset counts as one edge on the first cycle after reset.
- Reset in any state aborts the interrupt immediately. All outputs reach their reset values on the next edge.

## Timing
- Edge to pending: 2 cycles (input register, then pending set).
- pending to intWrite: 2 cycles (IDLE selects, ASSERT strobes).
- Peripheral edge to intWrite: 4 cycles minimum when the controller is idle.
- intr sampled high: pending and inService update on the same edge.
- End-of-interrupt to next intWrite: 1 cycle in IDLE plus 1 in ASSERT, so 2 cycles when work is eligible.
- intr is ignored in IDLE and ASSERT.
- All outputs are registered; there are no combinational paths from inputs.

## Configuration
- INTC_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to WAIT_ACK and increments each cycle while intr=0.
  - When it reaches ACK_TIMEOUT: set timeoutFlag, drop intN and the level, leave pending[idx] set, and return to IDLE. The request is re-arbitrated.
  - timeoutFlag clears only on Reset.
- INTC_TIMEOUT_EN undefined: WAIT_ACK waits indefinitely, no counter is built, and timeoutFlag is tied to 0.

## Structure
- Package intc_pkg holds:
  - FSM state encoding (2-bit)
  - the NUM_SRC=4 constant
  - the vector-shift constant (2)
- One sub-module: intc_arbiter. It is combinational and takes the eligible mask plus the four levels, returning a valid flag, the winner index and the winner level. This keeps the priority rule verifiable on its own.

## Test plan
- Reset then idle: devReq=0 for 10 cycles → all outputs 0, FSM in IDLE, no intWrite.
- Single request: devReq[2] rises; intr raised 3 cycles after intWrite and dropped 5 cycles later with intDataOut=0.
  - Response: int2=1, {intLvl1,intLvl0}=2'b10, intDataIn=16'h0048, intWrite high one cycle.
  - pending[2] clears at ack; outputs clear at end-of-interrupt.
- Priority: devReq[0] and devReq[3] rise in the same cycle → source 3 served first (intDataIn=16'h004C), then source 0 (16'h0040) after end-of-interrupt.
- Tie-break: LVL1=LVL2=2, both sources rise together → source 1 served first.
- Mask and re-request: end-of-interrupt with intDataOut=16'h8008 → mask=4'b1000. A later devReq[3] edge leaves pending[3]=1 with no intWrite. A re-edge of the in-service source during SERVICE produces a second intWrite after end-of-interrupt.
- Timeout (INTC_TIMEOUT_EN, ACK_TIMEOUT=8): no intr after intWrite → timeoutFlag=1 and pending bit still set. Arbitration restarts, giving a second intWrite. Reset asserted mid-SERVICE clears everything on the next edge.

Source files
------------

// File: rtl/intc_pkg.sv
// Shared types and constants for the interrupt controller.
package intc_pkg;

    localparam int unsigned NUM_SRC   = 4;
    localparam int unsigned IDX_W     = 2;
    localparam int unsigned LVL_W     = 2;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned VEC_SHIFT = 2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ASSERT   = 2'd1,
        ST_WAIT_ACK = 2'd2,
        ST_SERVICE  = 2'd3
    } state_t;

    // Handler vector for a source: base plus a word-aligned per-source offset.
    function automatic logic [DATA_W-1:0] vector_of(input logic [DATA_W-1:0] base,
                                                    input logic [IDX_W-1:0]  idx);
        return DATA_W'(base + (DATA_W'(idx) << VEC_SHIFT));
    endfunction

endpackage

// File: rtl/intc_arbiter.sv
// Fixed-level priority arbiter: highest level wins, lower index breaks ties.
module intc_arbiter
    import intc_pkg::*;
(
    input  logic [NUM_SRC-1:0]            eligible,
    input  logic [NUM_SRC-1:0][LVL_W-1:0] levels,
    output logic                          win_valid_c,
    output logic [IDX_W-1:0]              win_idx_c,
    output logic [LVL_W-1:0]              win_lvl_c
);

    // Scan upward; a strictly higher level is needed to displace the current pick.
    always_comb begin
        win_valid_c = 1'b0;
        win_idx_c   = '0;
        win_lvl_c   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (eligible[i] && (!win_valid_c || (levels[i] > win_lvl_c))) begin
                win_valid_c = 1'b1;
                win_idx_c   = IDX_W'(i);
                win_lvl_c   = levels[i];
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Source-side interrupt controller: edge-latched requests, fixed-level
// arbitration, and the intWrite/intr handshake toward the datapath.
// Optional acknowledge timeout is built when INTC_TIMEOUT_EN is defined.
module interrupt_controller
    import intc_pkg::*;
#(
    parameter logic [1:0]  LVL0        = 2'd0,
    parameter logic [1:0]  LVL1        = 2'd1,
    parameter logic [1:0]  LVL2        = 2'd2,
    parameter logic [1:0]  LVL3        = 2'd3,
    parameter logic [15:0] VECTOR_BASE = 16'h0040
`ifdef INTC_TIMEOUT_EN
    ,
    parameter logic [7:0]  ACK_TIMEOUT = 8'd64
`endif
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [3:0]  devReq,
    input  logic        intr,
    input  logic [15:0] intDataOut,
    output logic        int0,
    output logic        int1,
    output logic        int2,
    output logic        int3,
    output logic        intLvl1,
    output logic        intLvl0,
    output logic [15:0] intDataIn,
    output logic        intWrite,
    output logic [3:0]  pending,
    output logic [3:0]  inService,
    output logic [3:0]  mask,
    output logic        timeoutFlag
);

    state_t                         state, state_n;
    logic [NUM_SRC-1:0]             req_q, req_prev;
    logic [NUM_SRC-1:0]             edge_c, eligible_c;
    logic [NUM_SRC-1:0]             pending_n, in_service_n, mask_n;
    logic [NUM_SRC-1:0]             sel, sel_n;
    logic [LVL_W-1:0]               lvl, lvl_n;
    logic [IDX_W-1:0]               idx, idx_n;
    logic [DATA_W-1:0]              vec_n;
    logic                           write_n;
    logic                           win_valid_c;
    logic [IDX_W-1:0]               win_idx_c;
    logic [LVL_W-1:0]               win_lvl_c;
    logic [NUM_SRC-1:0][LVL_W-1:0]  levels;
    logic                           unused_data;

`ifdef INTC_TIMEOUT_EN
    logic [7:0] ack_cnt, ack_cnt_n;
    logic       timeout_q, timeout_n;
    assign timeoutFlag = timeout_q;
`else
    assign timeoutFlag = 1'b0;
`endif

    assign levels      = {LVL3, LVL2, LVL1, LVL0};
    assign edge_c      = req_q & ~req_prev;
    assign eligible_c  = pending & ~mask;
    assign {int3, int2, int1, int0} = sel;
    assign {intLvl1, intLvl0}       = lvl;
    assign unused_data = ^intDataOut[14:4];

    intc_arbiter u_arbiter (
        .eligible    (eligible_c),
        .levels      (levels),
        .win_valid_c (win_valid_c),
        .win_idx_c   (win_idx_c),
        .win_lvl_c   (win_lvl_c)
    );

    // Next-state and next-register values for the handshake FSM.
    always_comb begin
        state_n      = state;
        pending_n    = pending;
        in_service_n = inService;
        mask_n       = mask;
        sel_n        = sel;
        lvl_n        = lvl;
        idx_n        = idx;
        vec_n        = intDataIn;
        write_n      = 1'b0;
`ifdef INTC_TIMEOUT_EN
        ack_cnt_n    = ack_cnt;
        timeout_n    = timeout_q;
`endif
        case (state)
            ST_IDLE: begin
                if (win_valid_c) begin
                    idx_n   = win_idx_c;
                    sel_n   = NUM_SRC'(1) << win_idx_c;
                    lvl_n   = win_lvl_c;
                    vec_n   = vector_of(VECTOR_BASE, win_idx_c);
                    state_n = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                write_n   = 1'b1;
                state_n   = ST_WAIT_ACK;
`ifdef INTC_TIMEOUT_EN
                ack_cnt_n = '0;
`endif
            end
            ST_WAIT_ACK: begin
                if (intr) begin
                    pending_n[idx] = 1'b0;
                    in_service_n   = sel;
                    state_n        = ST_SERVICE;
                end
`ifdef INTC_TIMEOUT_EN
                else if (8'(ack_cnt + 8'd1) == ACK_TIMEOUT) begin
                    // Give up on this delivery; pending stays set so it re-arbitrates.
                    ack_cnt_n = 8'(ack_cnt + 8'd1);
                    timeout_n = 1'b1;
                    sel_n     = '0;
                    lvl_n     = '0;
                    state_n   = ST_IDLE;
                end else begin
                    ack_cnt_n = 8'(ack_cnt + 8'd1);
                end
`endif
            end
            ST_SERVICE: begin
                if (!intr) begin
                    in_service_n = '0;
                    sel_n        = '0;
                    lvl_n        = '0;
                    if (intDataOut[15]) begin
                        mask_n = intDataOut[NUM_SRC-1:0];
                    end
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
        // A new edge outranks the acknowledge clearing the same bit.
        pending_n = pending_n | edge_c;
    end

    // Register all state and outputs; synchronous reset aborts any interrupt.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state     <= ST_IDLE;
            req_q     <= '0;
            req_prev  <= '0;
            pending   <= '0;
            inService <= '0;
            mask      <= '0;
            sel       <= '0;
            lvl       <= '0;
            idx       <= '0;
            intDataIn <= '0;
            intWrite  <= 1'b0;
`ifdef INTC_TIMEOUT_EN
            ack_cnt   <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            req_q     <= devReq;
            req_prev  <= req_q;
            pending   <= pending_n;
            inService <= in_service_n;
            mask      <= mask_n;
            sel       <= sel_n;
            lvl       <= lvl_n;
            idx       <= idx_n;
            intDataIn <= vec_n;
            intWrite  <= write_n;
`ifdef INTC_TIMEOUT_EN
            ack_cnt   <= ack_cnt_n;
            timeout_q <= timeout_n;
`endif
        end
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// Scoreboard bench for interrupt_controller: expected deliveries are queued
// by the stimulus thread and checked by a monitor on every intWrite.
module tb_interrupt_controller;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [3:0]  devReq;
    logic        intr;
    logic [15:0] intDataOut;
    logic        int0, int1, int2, int3;
    logic        intLvl1, intLvl0;
    logic [15:0] intDataIn;
    logic        intWrite;
    logic [3:0]  pending, inService, mask;
    logic        timeoutFlag;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0]  src;
        logic [1:0]  lvl;
        logic [15:0] vec;
    } exp_t;

    exp_t exp_q[$];

    always #5 CLK = ~CLK;

    interrupt_controller #(
        .LVL0        (2'd0),
        .LVL1        (2'd2),
        .LVL2        (2'd2),
        .LVL3        (2'd3),
        .VECTOR_BASE (16'h0040)
`ifdef INTC_TIMEOUT_EN
        ,
        .ACK_TIMEOUT (8'd8)
`endif
    ) dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .devReq      (devReq),
        .intr        (intr),
        .intDataOut  (intDataOut),
        .int0        (int0),
        .int1        (int1),
        .int2        (int2),
        .int3        (int3),
        .intLvl1     (intLvl1),
        .intLvl0     (intLvl0),
        .intDataIn   (intDataIn),
        .intWrite    (intWrite),
        .pending     (pending),
        .inService   (inService),
        .mask        (mask),
        .timeoutFlag (timeoutFlag)
    );

    // Monitor: every intWrite must match the oldest queued expectation.
    always @(negedge CLK) begin : monitor
        exp_t got;
        exp_t want;
        if (!Reset && intWrite) begin
            got = '{src: {int3, int2, int1, int0}, lvl: {intLvl1, intLvl0}, vec: intDataIn};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got src=%b lvl=%b vec=%h, required no write",
                         got.src, got.lvl, got.vec);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("FAIL delivery: got src=%b lvl=%b vec=%h, required src=%b lvl=%b vec=%h",
                             got.src, got.lvl, got.vec, want.src, want.lvl, want.vec);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Wait for intWrite, returning edges elapsed; an expired bound is a failure.
    task automatic wait_write(input string name, input int limit, output int lat);
        lat = 0;
        for (int k = 1; k <= limit && lat == 0; k++) begin
            @(posedge CLK);
            #1;
            if (intWrite) lat = k;
        end
        if (lat == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: no intWrite within %0d cycles", name, limit);
        end
    endtask

    // Acknowledge the current interrupt and end it with the given data word.
    task automatic serve(input logic [15:0] dout);
        tick(1);
        intr = 1'b1;
        tick(3);
        intr       = 1'b0;
        intDataOut = dout;
        tick(1);
        intDataOut = '0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_sel"},     32'({int3, int2, int1, int0}), 32'h0);
        check({tag, "_lvl"},     32'({intLvl1, intLvl0}),       32'h0);
        check({tag, "_write"},   32'(intWrite),                 32'h0);
        check({tag, "_pending"}, 32'(pending),                  32'h0);
        check({tag, "_insvc"},   32'(inService),                32'h0);
        check({tag, "_mask"},    32'(mask),                     32'h0);
        check({tag, "_tflag"},   32'(timeoutFlag),              32'h0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stimulus
        int lat;
        Reset      = 1'b1;
        devReq     = '0;
        intr       = 1'b0;
        intDataOut = '0;
        tick(3);
        Reset = 1'b0;

        // Reset then idle
        tick(10);
        check_idle_outputs("reset");
        check("reset_vec", 32'(intDataIn), 32'h0);

        // Single request on source 2
        devReq = 4'b0100;
        exp_q.push_back('{src: 4'b0100, lvl: 2'b10, vec: 16'h0048});
        tick(1);
        check("single_pend_early", 32'(pending), 32'h0);
        tick(1);
        check("single_pend", 32'(pending), 32'h4);
        wait_write("single_write", 20, lat);
        check("pend_to_write", 32'(lat), 32'd2);
        devReq = '0;
        tick(1);
        check("single_strobe_width", 32'(intWrite), 32'h0);
        tick(2);
        intr = 1'b1;
        check("single_pend_preack", 32'(pending), 32'h4);
        tick(1);
        check("single_pend_ack", 32'(pending), 32'h0);
        check("single_insvc", 32'(inService), 32'h4);
        check("single_hold_sel", 32'({int3, int2, int1, int0}), 32'h4);
        check("single_hold_lvl", 32'({intLvl1, intLvl0}), 32'h2);
        check("single_hold_vec", 32'(intDataIn), 32'h0048);
        tick(4);
        intr = 1'b0;
        tick(1);
        check_idle_outputs("single_eoi");

        // Priority: sources 0 and 3 together
        devReq = 4'b1001;
        exp_q.push_back('{src: 4'b1000, lvl: 2'b11, vec: 16'h004C});
        exp_q.push_back('{src: 4'b0001, lvl: 2'b00, vec: 16'h0040});
        wait_write("prio_write3", 20, lat);
        check("edge_to_write", 32'(lat), 32'd4);
        check("prio_pending", 32'(pending), 32'h9);
        serve(16'h0000);
        wait_write("prio_write0", 20, lat);
        check("eoi_to_write", 32'(lat), 32'd2);
        serve(16'h0000);
        check("prio_done_pend", 32'(pending), 32'h0);
        devReq = '0;
        tick(2);

        // Tie-break: sources 1 and 2 share level 2
        devReq = 4'b0110;
        exp_q.push_back('{src: 4'b0010, lvl: 2'b10, vec: 16'h0044});
        exp_q.push_back('{src: 4'b0100, lvl: 2'b10, vec: 16'h0048});
        wait_write("tie_write1", 20, lat);
        serve(16'h0000);
        wait_write("tie_write2", 20, lat);
        serve(16'h0000);
        devReq = '0;
        tick(2);

`ifdef INTC_TIMEOUT_EN
        // Acknowledge timeout, re-arbitration, then reset mid-service
        devReq = 4'b0010;
        exp_q.push_back('{src: 4'b0010, lvl: 2'b10, vec: 16'h0044});
        exp_q.push_back('{src: 4'b0010, lvl: 2'b10, vec: 16'h0044});
        wait_write("to_write1", 20, lat);
        lat = 0;
        for (int k = 1; k <= 30 && lat == 0; k++) begin
            tick(1);
            if (timeoutFlag) lat = k;
        end
        check("to_flag", 32'(timeoutFlag), 32'h1);
        check("to_pending_kept", 32'(pending), 32'h2);
        check("to_sel_dropped", 32'(int1), 32'h0);
        wait_write("to_write2", 20, lat);
        tick(1);
        intr = 1'b1;
        tick(2);
        check("to_insvc", 32'(inService), 32'h2);
        Reset  = 1'b1;
        devReq = '0;
        tick(1);
        Reset = 1'b0;
        intr  = 1'b0;
        check_idle_outputs("mid_reset");
        check("mid_reset_vec", 32'(intDataIn), 32'h0);
        tick(2);
`else
        check("tflag_tied", 32'(timeoutFlag), 32'h0);
`endif

        // Mask update and re-request of the in-service source
        devReq = 4'b0001;
        exp_q.push_back('{src: 4'b0001, lvl: 2'b00, vec: 16'h0040});
        wait_write("mask_write1", 20, lat);
        tick(1);
        intr = 1'b1;
        tick(1);
        check("mask_pend_ack", 32'(pending), 32'h0);
        check("mask_insvc", 32'(inService), 32'h1);
        devReq = 4'b0000;
        tick(1);
        devReq = 4'b0001;
        tick(2);
        check("rereq_pending", 32'(pending), 32'h1);
        exp_q.push_back('{src: 4'b0001, lvl: 2'b00, vec: 16'h0040});
        intr       = 1'b0;
        intDataOut = 16'h8008;
        tick(1);
        intDataOut = '0;
        check("mask_set", 32'(mask), 32'h8);
        check("mask_eoi_insvc", 32'(inService), 32'h0);
        wait_write("rereq_write", 20, lat);
        check("rereq_latency", 32'(lat), 32'd2);
        serve(16'h0000);
        check("mask_unchanged", 32'(mask), 32'h8);
        devReq = '0;
        tick(2);
        devReq = 4'b1000;
        tick(8);
        check("masked_pending", 32'(pending), 32'h8);
        check("masked_no_sel", 32'(int3), 32'h0);
        devReq = '0;
        tick(4);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
